// File: rtl/bca_expander.sv
// Thermometer-code expander: builds a WIDTH-bit word with N ones packed at the LSB end,
// one bit per clock, behind the same start/done handshake as the bit counter.
module bca_expander #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CW-1:0]    count,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             sat
);

  // state   | meaning
  // S_IDLE  | waiting for start; last result and sat held
  // S_BUILD | shifting one 1 into result per clock until cnt_r reaches 0
  // S_DONE  | result valid; held until start drops
  typedef enum logic [1:0] {S_IDLE, S_BUILD, S_DONE} state_t;

  localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt_r, cnt_nxt;
  logic [WIDTH-1:0] result_r, result_nxt;
  logic             sat_r, sat_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt_r    <= '0;
      result_r <= '0;
      sat_r    <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt_r    <= cnt_nxt;
      result_r <= result_nxt;
      sat_r    <= sat_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt_r;
    result_nxt = result_r;
    sat_nxt    = sat_r;
    case (state)
      S_IDLE: begin
        if (start) begin
          // Clamp so the down-counter never asks for more bits than the word holds.
          cnt_nxt    = (count > WIDTH_C) ? WIDTH_C : count;
          sat_nxt    = (count > WIDTH_C);
          result_nxt = '0;
          state_nxt  = S_BUILD;
        end
      end
      S_BUILD: begin
        if (cnt_r != '0) begin
          result_nxt = {result_r[WIDTH-2:0], 1'b1};
          cnt_nxt    = cnt_r - 1'b1;
        end else begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (!start) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign result = result_r;
  assign sat    = sat_r;
  assign done   = (state == S_DONE);
  assign busy   = (state == S_BUILD);

endmodule

// File: tb/tb_bca_expander.sv
// Bench for bca_expander: vector table, randomized counts against a thermometer-code
// model, and hand-written sequences for mid-build start drop and async reset.
module tb_bca_expander;
  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk;
  logic          reset;
  logic          start;
  logic [CW-1:0] count;
  logic [W-1:0]  result;
  logic          done;
  logic          busy;
  logic          sat;

  int errors = 0;
  int checks = 0;

  bca_expander #(.WIDTH(W), .CW(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .count(count),
    .result(result), .done(done), .busy(busy), .sat(sat)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    int       n;
    logic [7:0] exp_res;
    logic     exp_sat;
    int       exp_lat;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: thermometer word holding k ones.
  function automatic logic [W-1:0] therm(input int k);
    int kc;
    logic [31:0] v;
    kc = (k > W) ? W : k;
    v = (32'd1 << kc) - 32'd1;
    return v[W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    check("done_busy_exclusive", {31'd0, done & busy}, 32'd0);
  endtask

  // Runs one conversion with start held; checks every build edge, latency, hold and return to idle.
  task automatic run_conv(input string tag, input int n, input logic [W-1:0] exp_res,
                          input logic exp_sat, input int exp_lat);
    int k;
    bit seen;
    count = CW'(n);
    start = 1'b1;
    tick();
    check($sformatf("%s busy_after_accept", tag), {31'd0, busy}, 32'd1);
    check($sformatf("%s result_cleared", tag), {24'd0, result}, 32'd0);
    k = 0;
    seen = 0;
    while (!seen && k < W + 4) begin
      tick();
      k++;
      if (done) seen = 1;
      else check($sformatf("%s result_edge%0d", tag, k), {24'd0, result}, {24'd0, therm(k)});
    end
    check($sformatf("%s latency", tag), k, exp_lat);
    check($sformatf("%s result", tag), {24'd0, result}, {24'd0, exp_res});
    check($sformatf("%s sat", tag), {31'd0, sat}, {31'd0, exp_sat});
    tick();
    tick();
    check($sformatf("%s done_held", tag), {31'd0, done}, 32'd1);
    check($sformatf("%s no_retrigger", tag), {24'd0, result}, {24'd0, exp_res});
    start = 1'b0;
    tick();
    check($sformatf("%s idle_done", tag), {30'd0, done, busy}, 32'd0);
    check($sformatf("%s idle_result_held", tag), {24'd0, result}, {24'd0, exp_res});
    check($sformatf("%s idle_sat_held", tag), {31'd0, sat}, {31'd0, exp_sat});
  endtask

  initial begin
    int k;
    bit seen;
    int n;

    vecs[0] = '{3,  8'h07, 1'b0, 4};
    vecs[1] = '{0,  8'h00, 1'b0, 1};
    vecs[2] = '{8,  8'hFF, 1'b0, 9};
    vecs[3] = '{12, 8'hFF, 1'b1, 9};
    vecs[4] = '{2,  8'h03, 1'b0, 3};
    vecs[5] = '{15, 8'hFF, 1'b1, 9};
    vecs[6] = '{1,  8'h01, 1'b0, 2};

    reset = 1'b1;
    start = 1'b0;
    count = '0;
    #5;
    check("reset result", {24'd0, result}, 32'd0);
    check("reset flags", {29'd0, done, busy, sat}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 7; i++)
      run_conv($sformatf("vec%0d", i), vecs[i].n, vecs[i].exp_res, vecs[i].exp_sat, vecs[i].exp_lat);

    // Async reset while idle with a held nonzero result, between clock edges.
    run_conv("pre_reset", 3, 8'h07, 1'b0, 4);
    #4;
    reset = 1'b1;
    #1;
    check("idle_async_reset result", {24'd0, result}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      n = $urandom_range(0, 15);
      run_conv($sformatf("rnd%0d_n%0d", i, n), n, therm(n), (n > W), ((n > W) ? W : n) + 1);
    end

    // Start dropped and count changed mid-build must not abort or alter the build.
    count = 4'd6;
    start = 1'b1;
    tick();
    tick();
    count = 4'd1;
    start = 1'b0;
    k = 1;
    seen = 0;
    while (!seen && k < W + 4) begin
      tick();
      k++;
      if (done) seen = 1;
    end
    check("drop_start latency", k, 7);
    check("drop_start result", {24'd0, result}, 32'h3F);
    tick();
    check("drop_start back_to_idle", {30'd0, done, busy}, 32'd0);
    check("drop_start result_held", {24'd0, result}, 32'h3F);

    // Async reset mid-build clears immediately.
    count = 4'd7;
    start = 1'b1;
    tick();
    tick();
    tick();
    tick();
    check("midbuild result_edge3", {24'd0, result}, 32'h07);
    #3;
    reset = 1'b1;
    #1;
    check("midbuild_reset result", {24'd0, result}, 32'd0);
    check("midbuild_reset flags", {29'd0, done, busy, sat}, 32'd0);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("after_reset stays_idle", {30'd0, done, busy}, 32'd0);

    run_conv("roundtrip", 5, 8'h1F, 1'b0, 6);
    check("roundtrip popcount", $countones(result), 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
